fir_tap_sequencer: RTL and testbench

Control FSM for the 16-bit, 64-tap FIR core, running in the fast MAC clock domain (clk2).
- Pops one sample from the input FIFO and writes it into the circular sample memory.
- Walks all taps, driving sample-memory and coefficient-memory read addresses, and issues accumulator clear/enable pipelined to match the MAC datapath latency.
- Strobes the output register once per sample.
- Arbitrates coefficient-memory loading (cload) against sample processing.

---
 rtl/fir_tap_sequencer.sv | 121 ++++++++++++
 tb/tb_fir_tap_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer: sample pop/write, tap walk and MAC control for the 64-tap FIR core (clk2 domain).
// Define FIR_SEQ_ERR_EN to add the sticky seq_err output flagging cload collisions with an active sequence.
module fir_tap_sequencer #(
    parameter int NTAPS   = 64,
    parameter int AW      = 6,
    parameter int MAC_LAT = 2
) (
    input  logic          clk2,
    input  logic          rst,
    input  logic          cload,
    input  logic [AW-1:0] caddr_in,
    input  logic          fifo_empty,
    output logic          fifo_rd,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_waddr,
    output logic [AW-1:0] dmem_raddr,
    output logic          cmem_we,
    output logic [AW-1:0] cmem_addr,
    output logic          acc_clr,
    output logic          acc_en,
    output logic          out_load,
`ifdef FIR_SEQ_ERR_EN
    output logic          seq_err,
`endif
    output logic          busy
);
    typedef enum logic [2:0] {IDLE, LOAD, POP, WR, MAC, DRAIN, OUT} state_t;
    state_t              state_q, state_d;
    logic [AW-1:0]       wptr_q, wptr_d;
    logic [AW-1:0]       newest_q, newest_d;
    logic [AW-1:0]       k_q, k_d;
    logic [MAC_LAT-1:0]  en_pipe_q, en_pipe_d;
    logic [MAC_LAT-1:0]  clr_pipe_q, clr_pipe_d;
    logic                tap_valid;
    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        newest_d   = newest_q;
        k_d        = k_q;
        fifo_rd    = 1'b0;
        dmem_we    = 1'b0;
        dmem_waddr = '0;
        dmem_raddr = '0;
        cmem_we    = 1'b0;
        cmem_addr  = '0;
        out_load   = 1'b0;
        tap_valid  = 1'b0;
        case (state_q)
            IDLE: begin
                cmem_we   = cload;
                cmem_addr = caddr_in;
                state_d   = cload ? LOAD : (!fifo_empty ? POP : IDLE);
            end
            LOAD: begin
                cmem_we   = cload;
                cmem_addr = caddr_in;
                state_d   = cload ? LOAD : IDLE;
            end
            POP: begin
                fifo_rd = 1'b1;
                state_d = WR;
            end
            WR: begin
                dmem_we    = 1'b1;
                dmem_waddr = wptr_q;
                newest_d   = wptr_q;
                wptr_d     = wptr_q + 1'b1;
                k_d        = '0;
                state_d    = MAC;
            end
            MAC: begin
                tap_valid  = 1'b1;
                dmem_raddr = newest_q - k_q;
                cmem_addr  = k_q;
                k_d        = k_q + 1'b1;
                state_d    = (k_q == AW'(NTAPS - 1)) ? DRAIN : MAC;
            end
            DRAIN: begin
                k_d     = (k_q == AW'(MAC_LAT - 1)) ? '0 : k_q + 1'b1;
                state_d = (k_q == AW'(MAC_LAT - 1)) ? OUT : DRAIN;
            end
            OUT: begin
                out_load = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Delay lines line up accumulator controls with the product reaching the accumulator.
        en_pipe_d  = MAC_LAT'({en_pipe_q, tap_valid});
        clr_pipe_d = MAC_LAT'({clr_pipe_q, tap_valid && (k_q == '0)});
    end
    assign acc_en  = en_pipe_q[MAC_LAT-1];
    assign acc_clr = clr_pipe_q[MAC_LAT-1] & acc_en;
    assign busy    = (state_q != IDLE);
    always_ff @(posedge clk2) begin
        if (rst) begin
            state_q    <= IDLE;
            wptr_q     <= '0;
            newest_q   <= '0;
            k_q        <= '0;
            en_pipe_q  <= '0;
            clr_pipe_q <= '0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            newest_q   <= newest_d;
            k_q        <= k_d;
            en_pipe_q  <= en_pipe_d;
            clr_pipe_q <= clr_pipe_d;
        end
    end
`ifdef FIR_SEQ_ERR_EN
    logic seq_err_q, seq_err_d;
    always_comb seq_err_d = seq_err_q | (cload && (state_q != IDLE) && (state_q != LOAD));
    always_ff @(posedge clk2) begin
        if (rst) seq_err_q <= 1'b0;
        else     seq_err_q <= seq_err_d;
    end
    assign seq_err = seq_err_q;
`endif
endmodule

// File: tb/tb_fir_tap_sequencer.sv
// tb_fir_tap_sequencer: scoreboard bench; expected per-cycle outputs are queued from the timing table and compared at negedge.
module tb_fir_tap_sequencer;
    logic       clk2 = 1'b0;
    logic       rst = 1'b1;
    logic       cload = 1'b0;
    logic [5:0] caddr_in = '0;
    logic       fifo_empty = 1'b1;
    logic       fifo_rd, dmem_we, cmem_we, acc_clr, acc_en, out_load, busy;
    logic [5:0] dmem_waddr, dmem_raddr, cmem_addr;
`ifdef FIR_SEQ_ERR_EN
    logic       seq_err;
`endif
    int         tests_run = 0;
    int         tests_failed = 0;
    int         cyc = 0;
    logic [24:0] exp_q[$];

    fir_tap_sequencer #(.NTAPS(64), .AW(6), .MAC_LAT(2)) dut (
        .clk2(clk2), .rst(rst), .cload(cload), .caddr_in(caddr_in), .fifo_empty(fifo_empty),
        .fifo_rd(fifo_rd), .dmem_we(dmem_we), .dmem_waddr(dmem_waddr), .dmem_raddr(dmem_raddr),
        .cmem_we(cmem_we), .cmem_addr(cmem_addr), .acc_clr(acc_clr), .acc_en(acc_en),
        .out_load(out_load),
`ifdef FIR_SEQ_ERR_EN
        .seq_err(seq_err),
`endif
        .busy(busy)
    );

    always #5 clk2 = ~clk2;

    function automatic logic [24:0] pk(input logic fr, input logic dw, input logic [5:0] wa,
                                       input logic [5:0] ra, input logic cw, input logic [5:0] ca,
                                       input logic clr, input logic en, input logic ol, input logic by);
        return {fr, dw, wa, ra, cw, ca, clr, en, ol, by};
    endfunction

    // Cycle 0 is the IDLE cycle with fifo_empty low; cycles 0..n-1 of one sample are queued.
    function automatic void push_sample(input logic [5:0] w, input int n);
        logic [5:0] k;
        logic       mac;
        for (int i = 0; i < n; i++) begin
            k   = 6'(i - 3);
            mac = (i >= 3) && (i <= 66);
            exp_q.push_back(pk(i == 1, i == 2, (i == 2) ? w : 6'd0, mac ? 6'(w - k) : 6'd0, 1'b0,
                               mac ? k : 6'd0, i == 5, (i >= 5) && (i <= 68), i == 69, i != 0));
        end
    endfunction

    function automatic void push_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back('0);
    endfunction

    task automatic step(input string nm);
        logic [24:0] act, e;
        @(negedge clk2);
        act = {fifo_rd, dmem_we, dmem_waddr, dmem_raddr, cmem_we, cmem_addr, acc_clr, acc_en, out_load, busy};
        tests_run++;
        if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL %s cyc %0d: scoreboard empty, outputs %h", nm, cyc, act);
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                tests_failed++;
                $display("FAIL %s cyc %0d: got %h expected %h", nm, cyc, act, e);
            end
        end
        cyc++;
        @(posedge clk2);
        #1;
    endtask

    task automatic run_sample(input string nm, input logic [5:0] w, input bit hold);
        push_sample(w, 70);
        step(nm);
        if (!hold) fifo_empty = 1'b1;
        repeat (69) step(nm);
    endtask

    task automatic test_reset();
        cyc = 0;
        repeat (3) @(posedge clk2);
        #1;
        rst = 1'b0;
        push_idle(20);
        repeat (20) step("reset_idle");
`ifdef FIR_SEQ_ERR_EN
        tests_run++;
        if (seq_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_seq_err: got %b expected 0", seq_err);
        end
`endif
    endtask

    task automatic test_coef_load();
        cyc = 0;
        for (int j = 0; j < 64; j++) begin
            cload = 1'b1;
            caddr_in = 6'(j);
            fifo_empty = 1'b0;
            exp_q.push_back(pk(0, 0, 0, 0, 1, 6'(j), 0, 0, 0, j != 0));
            step("coef_load");
        end
        cload = 1'b0;
        caddr_in = '0;
        exp_q.push_back(pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        step("coef_load_end");
    endtask

    task automatic test_first_sample();
        cyc = 0;
        run_sample("first_sample", 6'd0, 1'b0);
        push_idle(1);
        step("first_sample_idle");
    endtask

    task automatic test_back_to_back();
        rst = 1'b1;
        @(posedge clk2);
        #1;
        rst = 1'b0;
        fifo_empty = 1'b0;
        for (int n = 0; n < 65; n++) begin
            cyc = 0;
            run_sample("back_to_back", 6'(n), n != 64);
        end
        cyc = 0;
        push_idle(2);
        repeat (2) step("back_to_back_idle");
    endtask

    task automatic test_collision();
        cyc = 0;
        fifo_empty = 1'b0;
        push_sample(6'd1, 70);
        exp_q.push_back(pk(0, 0, 0, 0, 1, 6'd5, 0, 0, 0, 0));
        exp_q.push_back(pk(0, 0, 0, 0, 1, 6'd5, 0, 0, 0, 1));
        exp_q.push_back(pk(0, 0, 0, 0, 0, 6'd0, 0, 0, 0, 1));
        push_idle(1);
        step("collision");
        fifo_empty = 1'b1;
        repeat (12) step("collision");
        cload = 1'b1;
        caddr_in = 6'd5;
`ifdef FIR_SEQ_ERR_EN
        tests_run++;
        if (seq_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL seq_err_early: got %b expected 0", seq_err);
        end
`endif
        step("collision");
`ifdef FIR_SEQ_ERR_EN
        tests_run++;
        if (seq_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL seq_err_set: got %b expected 1", seq_err);
        end
`endif
        repeat (58) step("collision");
        cload = 1'b0;
        caddr_in = '0;
        repeat (2) step("collision_load");
    endtask

    task automatic test_reset_mid_mac();
        cyc = 0;
        fifo_empty = 1'b0;
        push_sample(6'd2, 34);
        push_idle(42);
        step("reset_mid_mac");
        fifo_empty = 1'b1;
        repeat (32) step("reset_mid_mac");
        rst = 1'b1;
        step("reset_mid_mac");
        rst = 1'b0;
        repeat (42) step("reset_mid_mac_idle");
`ifdef FIR_SEQ_ERR_EN
        tests_run++;
        if (seq_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL seq_err_cleared: got %b expected 0", seq_err);
        end
`endif
        cyc = 0;
        fifo_empty = 1'b0;
        run_sample("after_reset_sample", 6'd0, 1'b0);
        push_idle(1);
        step("after_reset_idle");
    endtask

    initial begin
        test_reset();
        test_coef_load();
        test_first_sample();
        test_back_to_back();
        test_collision();
        test_reset_mid_mac();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
